bcd_timekeeper: RTL

- Parametrised BCD time-of-day counter, successor to the fixed 12-hour clock block.
- Selectable 12h/24h mode, built-in seconds prescaler, validated time-load port, and a day-rollover strobe.
- Sits between the board tick generator and the display/alarm logic in the Timers area.

---
 rtl/timer_pkg.sv | 28 ++
 rtl/bcd_wrap_counter.sv | 32 +++
 rtl/bcd_timekeeper.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared BCD types, constants and helpers for the timer blocks.
package timer_pkg;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t BCD_00 = 8'h00;
    localparam bcd2_t BCD_01 = 8'h01;
    localparam bcd2_t BCD_11 = 8'h11;
    localparam bcd2_t BCD_12 = 8'h12;
    localparam bcd2_t BCD_23 = 8'h23;
    localparam bcd2_t BCD_59 = 8'h59;

    // Both digits must be decimal; once they are, BCD order matches binary order.
    function automatic logic bcd_valid(bcd2_t v, bcd2_t max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    function automatic bcd2_t bcd_inc(bcd2_t v);
        bcd2_t r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD counter running MIN..MAX; wrap flags the MAX->MIN step as the carry out.
module bcd_wrap_counter
    import timer_pkg::*;
#(
    parameter bcd2_t MIN = 8'h00,
    parameter bcd2_t MAX = 8'h59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] q,
    output logic       wrap
);

    bcd2_t r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= MIN;
        end else if (load) begin
            r_q <= load_val;
        end else if (inc) begin
            r_q <= (r_q == MAX) ? MIN : bcd_inc(r_q);
        end
    end

    assign q    = r_q;
    assign wrap = inc && (r_q == MAX);

endmodule

// File: rtl/bcd_timekeeper.sv
// BCD time-of-day counter: 12h/24h mode, seconds prescaler, validated load, day strobe.
// Optional alarm comparator enabled by defining TIMEKEEPER_ALARM_EN.
module bcd_timekeeper
    import timer_pkg::*;
#(
    parameter int MODE_24H = 0,
    parameter int TICK_DIV = 1,
    parameter int DIV_W    = $clog2(TICK_DIV) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       load_pm,
`ifdef TIMEKEEPER_ALARM_EN
    input  logic       alarm_set,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_pm,
    input  logic       alarm_clr,
    output logic       alarm,
`endif
    output logic       load_ack,
    output logic       load_err,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       day_tick
);

    localparam bcd2_t            HH_RST   = (MODE_24H != 0) ? BCD_00 : BCD_12;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    bcd2_t            r_hh;
    logic             r_pm;
    logic             r_day;
    logic             r_ack;
    logic             r_err;

    logic  w_hh_ok;
    logic  w_load_valid;
    logic  w_load_ok;
    logic  w_load_pm;
    logic  w_sec_adv;
    logic  w_adv;
    bcd2_t w_ss;
    bcd2_t w_mm;
    logic  w_ss_wrap;
    logic  w_mm_wrap;
    bcd2_t w_hh_next;
    logic  w_pm_next;
    logic  w_day_wrap;

    assign w_hh_ok      = (MODE_24H != 0) ? bcd_valid(load_hh, BCD_23)
                                          : (bcd_valid(load_hh, BCD_12) && (load_hh != BCD_00));
    assign w_load_valid = w_hh_ok && bcd_valid(load_mm, BCD_59) && bcd_valid(load_ss, BCD_59);
    assign w_load_ok    = load && w_load_valid;
    assign w_load_pm    = (MODE_24H != 0) ? (load_hh >= BCD_12) : load_pm;

    // A valid load takes precedence over a coincident one-second advance.
    assign w_sec_adv = ena && (r_div == DIV_LAST);
    assign w_adv     = w_sec_adv && !w_load_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (w_load_ok) begin
            r_div <= '0;
        end else if (ena) begin
            r_div <= w_sec_adv ? '0 : r_div + DIV_W'(1);
        end
    end

    bcd_wrap_counter #(.MIN(BCD_00), .MAX(BCD_59)) u_ss (
        .clk      (clk),
        .reset    (reset),
        .inc      (w_adv),
        .load     (w_load_ok),
        .load_val (load_ss),
        .q        (w_ss),
        .wrap     (w_ss_wrap)
    );

    bcd_wrap_counter #(.MIN(BCD_00), .MAX(BCD_59)) u_mm (
        .clk      (clk),
        .reset    (reset),
        .inc      (w_ss_wrap),
        .load     (w_load_ok),
        .load_val (load_mm),
        .q        (w_mm),
        .wrap     (w_mm_wrap)
    );

    // In 12h mode pm flips entering 12, and only the PM->AM flip is midnight.
    always_comb begin
        w_hh_next  = r_hh;
        w_pm_next  = r_pm;
        w_day_wrap = 1'b0;
        if (MODE_24H != 0) begin
            if (r_hh == BCD_23) begin
                w_hh_next  = BCD_00;
                w_day_wrap = 1'b1;
            end else begin
                w_hh_next = bcd_inc(r_hh);
            end
            w_pm_next = (w_hh_next >= BCD_12);
        end else begin
            if (r_hh == BCD_11) begin
                w_hh_next  = BCD_12;
                w_pm_next  = !r_pm;
                w_day_wrap = r_pm;
            end else if (r_hh == BCD_12) begin
                w_hh_next = BCD_01;
            end else begin
                w_hh_next = bcd_inc(r_hh);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hh  <= HH_RST;
            r_pm  <= 1'b0;
            r_day <= 1'b0;
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= w_load_ok;
            r_err <= load && !w_load_valid;
            r_day <= 1'b0;
            if (w_load_ok) begin
                r_hh <= load_hh;
                r_pm <= w_load_pm;
            end else if (w_mm_wrap) begin
                r_hh  <= w_hh_next;
                r_pm  <= w_pm_next;
                r_day <= w_day_wrap;
            end
        end
    end

`ifdef TIMEKEEPER_ALARM_EN
    bcd2_t r_al_hh;
    bcd2_t r_al_mm;
    logic  r_al_pm;
    logic  r_alarm;
    bcd2_t w_mm_after;
    bcd2_t w_hh_after;
    logic  w_pm_after;
    logic  w_alarm_hit;

    // Match against the time this edge produces; ss wrapping implies counting, never a load.
    assign w_mm_after  = (w_mm == BCD_59) ? BCD_00 : bcd_inc(w_mm);
    assign w_hh_after  = w_mm_wrap ? w_hh_next : r_hh;
    assign w_pm_after  = w_mm_wrap ? w_pm_next : r_pm;
    assign w_alarm_hit = w_ss_wrap && (w_mm_after == r_al_mm) && (w_hh_after == r_al_hh)
                         && ((MODE_24H != 0) || (w_pm_after == r_al_pm));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_al_hh <= HH_RST;
            r_al_mm <= BCD_00;
            r_al_pm <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            if (alarm_set) begin
                r_al_hh <= alarm_hh;
                r_al_mm <= alarm_mm;
                r_al_pm <= alarm_pm;
            end
            if (w_alarm_hit) begin
                r_alarm <= 1'b1;
            end else if (alarm_clr) begin
                r_alarm <= 1'b0;
            end
        end
    end

    assign alarm = r_alarm;
`endif

    assign load_ack = r_ack;
    assign load_err = r_err;
    assign hh       = r_hh;
    assign mm       = w_mm;
    assign ss       = w_ss;
    assign pm       = r_pm;
    assign day_tick = r_day;

endmodule
